// File: rtl/multiplier_taint_track_radix.sv
// multiplier_taint_track_radix: sequential shift-add multiplier retiring
// DIGIT_BITS multiplier bits per cycle, with signed/unsigned mode, optional
// early termination and 1-bit-per-word taint shadow logic.
module multiplier_taint_track_radix #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIGIT_BITS = 1,
    parameter int unsigned EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               start_t,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               multiplier_t,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic               multiplicand_t,
    input  logic               signed_mode,
    input  logic               signed_mode_t,
    output logic               busy,
    output logic               busy_t,
    output logic [2*WIDTH-1:0] product,
    output logic               product_t,
    output logic               productDone,
    output logic               productDone_t
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned DIGITS = WIDTH / DIGIT_BITS;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam logic        EE     = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mreg;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      sum;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               in_t;
    logic               ctrl_t;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      sum_next;
    logic [WIDTH-1:0]   mreg_next;
    logic               run_last;

    // Operand magnitudes; the most negative value wraps to its unsigned magnitude
    always_comb begin
        a_abs = (signed_mode && multiplier[WIDTH-1])   ? WIDTH'(-multiplier)   : multiplier;
        b_abs = (signed_mode && multiplicand[WIDTH-1]) ? WIDTH'(-multiplicand) : multiplicand;
    end

    // One digit of partial product, next accumulator and the last-digit decision
    always_comb begin
        pp = '0;
        for (int i = 0; i < int'(DIGIT_BITS); i++) begin
            if (mreg[i]) begin
                pp = pp + (mcand << i);
            end
        end
        sum_next  = sum + pp;
        mreg_next = mreg >> DIGIT_BITS;
        run_last  = (cnt == CNT_W'(1)) || (EE && (mreg_next == '0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (run_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state register; control taint covers them
    always_comb begin
        busy          = (state != IDLE);
        productDone   = (state == DONE);
        busy_t        = ctrl_t;
        productDone_t = ctrl_t;
    end

    // Datapath, result register and taint shadow state
    always_ff @(posedge clk) begin
        if (rst) begin
            mreg      <= '0;
            mcand     <= '0;
            sum       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            in_t      <= 1'b0;
            ctrl_t    <= 1'b0;
            product   <= '0;
            product_t <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Accept depends on start; with early exit, latency depends on A and mode
                    ctrl_t <= ctrl_t | start_t
                              | (start & EE & (multiplier_t | signed_mode_t));
                    if (start) begin
                        neg   <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
                        mreg  <= a_abs;
                        mcand <= PW'(b_abs);
                        sum   <= '0;
                        cnt   <= CNT_W'(DIGITS);
                        in_t  <= multiplier_t | multiplicand_t | signed_mode_t;
                    end
                end
                RUN: begin
                    sum   <= sum_next;
                    mcand <= mcand << DIGIT_BITS;
                    mreg  <= mreg_next;
                    cnt   <= cnt - CNT_W'(1);
                    if (run_last) begin
                        product   <= neg ? PW'(-sum_next) : sum_next;
                        product_t <= in_t | ctrl_t;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_taint_track_radix.sv
// Directed bench: one full-latency instance (DIGIT_BITS=2) and one
// early-exit instance sharing clock, reset and inputs.
module tb_multiplier_taint_track_radix;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start_t;
    logic [W-1:0] multiplier, multiplicand;
    logic         multiplier_t, multiplicand_t;
    logic         signed_mode, signed_mode_t;

    logic           busy_a, busy_t_a, product_t_a, done_a, done_t_a;
    logic [2*W-1:0] product_a;
    logic           busy_b, busy_t_b, product_t_b, done_b, done_t_b;
    logic [2*W-1:0] product_b;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_taint_track_radix #(.WIDTH(W), .DIGIT_BITS(2), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
        .busy(busy_a), .busy_t(busy_t_a), .product(product_a), .product_t(product_t_a),
        .productDone(done_a), .productDone_t(done_t_a)
    );

    multiplier_taint_track_radix #(.WIDTH(W), .DIGIT_BITS(2), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst(rst), .start(start), .start_t(start_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
        .busy(busy_b), .busy_t(busy_t_b), .product(product_b), .product_t(product_t_b),
        .productDone(done_b), .productDone_t(done_t_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observations of one operation, cycle c being the one after accept edge c
    int   dc_a, dc_b, bc_a, bc_b, dn_a, dn_b;
    logic dt_a, dt_b, bt_a, bt_b;

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input logic mt, input logic mct, input logic smt);
        dc_a = -1; dc_b = -1; bc_a = 0; bc_b = 0; dn_a = 0; dn_b = 0;
        dt_a = 1'b0; dt_b = 1'b0; bt_a = 1'b0; bt_b = 1'b0;
        @(negedge clk);
        multiplier = a; multiplicand = b; signed_mode = sm;
        multiplier_t = mt; multiplicand_t = mct; signed_mode_t = smt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bt_a = busy_t_a;
                bt_b = busy_t_b;
            end
            if (busy_a) bc_a++;
            if (busy_b) bc_b++;
            if (done_a) begin
                if (dn_a == 0) dc_a = c;
                dn_a++;
                dt_a = done_t_a;
            end
            if (done_b) begin
                if (dn_b == 0) dc_b = c;
                dn_b++;
                dt_b = done_t_b;
            end
        end
        multiplier_t = 1'b0; multiplicand_t = 1'b0; signed_mode_t = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_t = 1'b0;
        multiplier = '0; multiplicand = '0; signed_mode = 1'b0;
        multiplier_t = 1'b0; multiplicand_t = 1'b0; signed_mode_t = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy_a), 64'd0);
        check("reset_done", 64'(done_a), 64'd0);
        check("reset_product", 64'(product_a), 64'd0);
        check("reset_taints", 64'({busy_t_a, product_t_a, done_t_a, busy_t_b}), 64'd0);
        rst = 1'b0;

        // 13 * 11 unsigned
        run_op(8'd13, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("u13x11_busy_cycles", 64'(bc_a), 64'd5);
        check("u13x11_done_cycle", 64'(dc_a), 64'd4);
        check("u13x11_done_count", 64'(dn_a), 64'd1);
        check("u13x11_product", 64'(product_a), 64'h008F);
        check("u13x11_taints", 64'({busy_t_a, product_t_a, dt_a}), 64'd0);
        check("u13x11_early_cycle", 64'(dc_b), 64'd2);
        check("u13x11_early_product", 64'(product_b), 64'h008F);

        // -3 * 5 signed
        run_op(8'hFD, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s_m3x5_product", 64'(product_a), 64'hFFF1);
        check("s_m3x5_early_cycle", 64'(dc_b), 64'd1);
        check("s_m3x5_early_product", 64'(product_b), 64'hFFF1);

        // -128 * -128 signed
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        check("s_m128sq_product", 64'(product_a), 64'h4000);
        check("s_m128sq_early_cycle", 64'(dc_b), 64'd4);

        // 255 * 255 unsigned
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("u255sq_product", 64'(product_a), 64'hFE01);
        check("u255sq_early_product", 64'(product_b), 64'hFE01);

        // Data taint on B reaches product only
        run_op(8'd2, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mcandt_product", 64'(product_a), 64'd6);
        check("mcandt_product_t", 64'(product_t_a), 64'd1);
        check("mcandt_ctrl_t", 64'({bt_a, dt_a, busy_t_a}), 64'd0);
        check("mcandt_early_ctrl_t", 64'({bt_b, dt_b}), 64'd0);

        run_op(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clean_product_t", 64'(product_t_a), 64'd0);
        check("clean_product", 64'(product_a), 64'd1);

        // Early exit: 3 * 7
        run_op(8'd3, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ee_3x7_done_cycle", 64'(dc_b), 64'd1);
        check("ee_3x7_product", 64'(product_b), 64'd21);
        check("ee_3x7_busy_cycles", 64'(bc_b), 64'd2);

        // Multiplier taint makes early-exit control tainted and sticky
        run_op(8'd3, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ee_mt_busy_t", 64'(bt_b), 64'd1);
        check("ee_mt_done_t", 64'(dt_b), 64'd1);
        check("ee_mt_product_t", 64'(product_t_b), 64'd1);
        check("full_mt_ctrl_t", 64'({bt_a, dt_a}), 64'd0);
        check("full_mt_product_t", 64'(product_t_a), 64'd1);
        repeat (3) @(negedge clk);
        check("ee_mt_sticky", 64'({busy_t_b, done_t_b}), 64'b11);
        pulse_rst();
        check("ee_rst_clears", 64'({busy_t_b, product_t_b, product_b}), 64'd0);

        // start_t while idle taints control
        @(negedge clk);
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        check("start_t_ctrl", 64'({busy_t_a, busy_t_b}), 64'b11);
        run_op(8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_t_done_t", 64'(dt_a), 64'd1);
        check("start_t_product_t", 64'(product_t_a), 64'd1);
        check("start_t_product", 64'(product_a), 64'd4);

        // Reset at edge 2 of 200 * 200
        @(negedge clk);
        multiplier = 8'd200; multiplicand = 8'd200; signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'({busy_a, busy_b}), 64'd0);
        check("abort_product", 64'({product_a, product_b}), 64'd0);
        check("abort_taints", 64'({busy_t_a, product_t_a, done_t_a, busy_t_b}), 64'd0);
        dn_a = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_a || done_b) dn_a++;
        end
        check("abort_no_done", 64'(dn_a), 64'd0);
        run_op(8'd200, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_abort_product", 64'(product_a), 64'h9C40);
        check("after_abort_done_cycle", 64'(dc_a), 64'd4);
        check("after_abort_early_product", 64'(product_b), 64'h9C40);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_taint_track_radix.md
# multiplier_taint_track_radix

Parametrised sequential shift-add multiplier with 1-bit-per-word taint tracking. It is the next generation of the team's taint-tracked multiplier. Over that block it adds a configurable radix (DIGIT_BITS multiplier bits retired per cycle), a run-time signed/unsigned mode, optional data-dependent early termination, and a busy indicator. Control, datapath and taint shadow logic live in one block, which sits in the same place in the design as the taint-tracked multiplier it generalises.

## Interface
- WIDTH, 32: operand width; product is 2*WIDTH.
- DIGIT_BITS, 1: multiplier bits retired per RUN cycle. Legal values are 1, 2 or 4, and must divide WIDTH.
- EARLY_EXIT, 0: 1 = finish when the remaining multiplier bits are zero. This makes timing data-dependent.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start / start_t  in  1 / 1  request to begin; taint of start.
- multiplier / multiplier_t  in  WIDTH / 1  operand A; word taint.
- multiplicand / multiplicand_t  in  WIDTH / 1  operand B; word taint.
- signed_mode / signed_mode_t  in  1 / 1  1 = two's-complement operands; taint.
- busy / busy_t  out  1 / 1  high when state != IDLE; taint.
- product / product_t  out  2*WIDTH / 1  result, held until the next completion; taint.
- productDone / productDone_t  out  1 / 1  one-cycle completion pulse; taint.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE. rst forces every register, output and taint bit to 0.
- Transitions:
  - IDLE→RUN when start=1 (accept). Otherwise stay in IDLE.
  - RUN→DONE when the digit count expires. With EARLY_EXIT=1, also when the shifted multiplier register is zero.
  - DONE→IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queueing.
- On accept:
  - neg ← signed_mode & (A[W-1] ^ B[W-1]).
  - mreg ← |A| and mcand ← |B|, zero-extended to 2*WIDTH. Absolute value is taken only in signed mode; -2^(W-1) maps to 2^(W-1) unsigned.
  - sum ← 0; cnt ← WIDTH/DIGIT_BITS.
  - Latch in_t ← multiplier_t | multiplicand_t | signed_mode_t.
- Each RUN cycle:
  - sum ← sum + mcand * mreg[DIGIT_BITS-1:0], mod 2^(2W).
  - mcand ← mcand << DIGIT_BITS.
  - mreg ← mreg >> DIGIT_BITS.
  - cnt ← cnt-1.
- Entering DONE: product ← neg ? -sum : sum (two's complement, 2*WIDTH bits), and product_t ← in_t. productDone=1 for the DONE cycle only.
- Control taint ctrl_t is sticky and cleared only by rst.
  - In IDLE, each cycle: ctrl_t ← ctrl_t | start_t. The accept decision depends on start.
  - On accept with EARLY_EXIT=1: ctrl_t ← ctrl_t | multiplier_t | signed_mode_t. Completion time depends on A.
- busy_t = productDone_t = ctrl_t.
- product_t also ORs in ctrl_t at the completion write, because which result is held depends on control.

## Timing
- Accept at edge 0 (start=1 sampled in IDLE).
- RUN occupies edges 1..N.
  - EARLY_EXIT=0: N = WIDTH/DIGIT_BITS.
  - EARLY_EXIT=1: N = max(1, index of the most-significant nonzero digit of |A|, counting from 1).
- DONE state, with productDone=1, lasts from edge N until edge N+1. IDLE resumes at edge N+1; the earliest next accept is edge N+1.
- busy is high from edge 0 through edge N+1 (exclusive).
- product/product_t update only at the DONE-entry edge. They are stable at all other times, including through a subsequent RUN.
- rst mid-RUN or mid-DONE:
  - Next cycle is IDLE.
  - product, product_t, ctrl_t and all other outputs are 0.
  - No productDone pulse is issued for the aborted operation.
- start=1 and rst=1 on the same edge: rst wins, and there is no accept.

## Test plan
- WIDTH=8, DIGIT_BITS=2, EARLY_EXIT=0, unsigned, A=13, B=11, no taint -> busy high for 5 cycles after accept; productDone pulse in the cycle after edge 4; product=0x008F; all _t outputs 0.
- Same config, signed: A=-3, B=5 -> product=0xFFF1. Then A=B=-128 -> product=0x4000. Finally unsigned A=B=255 -> product=0xFE01.
- Taint isolation, EARLY_EXIT=0: multiplicand_t=1 -> product_t=1 at done; busy_t=productDone_t=0. Next operation with clean inputs -> product_t=0.
- EARLY_EXIT=1, DIGIT_BITS=2: A=3, B=7 -> productDone in the cycle after edge 1 and product=21. Repeat with multiplier_t=1 -> busy_t, productDone_t and product_t are 1 and stay 1 until rst.
- start_t=1 with start=0 held in IDLE for one cycle -> ctrl_t=1. The next completion has productDone_t=1 and product_t=1.
- rst at edge 2 of an 8-bit operation (A=200, B=200) -> IDLE with all outputs 0 after that edge, no productDone pulse. A new accept then completes with product=40000 (0x9C40).
